// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: programmable divided-clock controller.
// Holds the half-period and burst-length configuration behind a valid/ready
// port and sequences start / stop / burst operation of a registered divided
// clock. The divided clock never produces a high phase shorter than H+1
// cycles: a stop that arrives while clkout is high waits for the falling edge.
module clk_div_ctrl #(
    parameter int          CNT_W     = 32,
    parameter int          BURST_W   = 16,
    parameter int unsigned DEF_HALF  = 25,
    parameter int unsigned DEF_BURST = 0
) (
    input  logic               clkin,
    input  logic               resetn,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [CNT_W-1:0]   cfg_half,
    input  logic [BURST_W-1:0] cfg_burst,
    input  logic               start,
    input  logic               stop,
    output logic               clkout,
    output logic               tick,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RUN      = 2'd1,
        ST_STOPPING = 2'd2
    } state_t;

    state_t             state_r;
    state_t             state_nxt;

    logic [CNT_W-1:0]   half_r;
    logic [BURST_W-1:0] burst_r;
    logic [CNT_W-1:0]   cnt_r;
    logic [BURST_W-1:0] bcnt_r;
    logic               clkout_r;
    logic               tick_r;
    logic               done_r;
    logic               busy_r;
    logic               cfg_ready_r;
    logic               burst_stop_r;

    logic [CNT_W-1:0]   half_nxt;
    logic [BURST_W-1:0] burst_nxt;
    logic [CNT_W-1:0]   cnt_nxt;
    logic [BURST_W-1:0] bcnt_nxt;
    logic               clkout_nxt;
    logic               tick_nxt;
    logic               done_nxt;
    logic               burst_stop_nxt;

    logic               wrap_s;
    logic               rise_s;
    logic               fall_s;
    logic [BURST_W-1:0] bcnt_inc_s;
    logic               burst_hit_s;

    // Toggle point is reached when the half-period counter equals H.
    assign wrap_s      = (cnt_r == half_r);
    // Rising toggles only happen while running; STOPPING is always entered high.
    assign rise_s      = (state_r == ST_RUN) && wrap_s && !clkout_r;
    assign fall_s      = (state_r != ST_IDLE) && wrap_s && clkout_r;
    // Burst edge counter saturates at all-ones.
    assign bcnt_inc_s  = (&bcnt_r) ? bcnt_r : (bcnt_r + {{(BURST_W-1){1'b0}}, 1'b1});
    // Final rising edge of a finite burst; takes precedence over stop.
    assign burst_hit_s = rise_s && (burst_r != {BURST_W{1'b0}}) && (bcnt_inc_s == burst_r);

    // State register.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Next-state selection: start/stop sequencing and burst completion.
    always_comb begin
        state_nxt = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nxt = ST_RUN;
                end else begin
                    state_nxt = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (burst_hit_s) begin
                    state_nxt = ST_STOPPING;
                end else if (stop) begin
                    // Low phase, or high phase ending right now: leave at once.
                    if (!clkout_r || fall_s) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        state_nxt = ST_STOPPING;
                    end
                end else begin
                    state_nxt = ST_RUN;
                end
            end
            ST_STOPPING: begin
                if (fall_s) begin
                    state_nxt = ST_IDLE;
                end else begin
                    state_nxt = ST_STOPPING;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Next values for the counters, configuration and registered outputs.
    always_comb begin
        half_nxt       = half_r;
        burst_nxt      = burst_r;
        cnt_nxt        = cnt_r;
        bcnt_nxt       = bcnt_r;
        clkout_nxt     = clkout_r;
        tick_nxt       = 1'b0;
        done_nxt       = 1'b0;
        burst_stop_nxt = burst_stop_r;
        if (state_r == ST_IDLE) begin
            cnt_nxt        = {CNT_W{1'b0}};
            bcnt_nxt       = {BURST_W{1'b0}};
            clkout_nxt     = 1'b0;
            burst_stop_nxt = 1'b0;
            // Writing in the start cycle means the run sees the new values.
            if (cfg_valid && cfg_ready_r) begin
                half_nxt  = cfg_half;
                burst_nxt = cfg_burst;
            end else begin
                half_nxt  = half_r;
                burst_nxt = burst_r;
            end
        end else if (state_nxt == ST_IDLE) begin
            cnt_nxt        = {CNT_W{1'b0}};
            clkout_nxt     = 1'b0;
            done_nxt       = (state_r == ST_STOPPING) && burst_stop_r;
            burst_stop_nxt = 1'b0;
        end else begin
            if (wrap_s) begin
                cnt_nxt    = {CNT_W{1'b0}};
                clkout_nxt = !clkout_r;
            end else begin
                cnt_nxt    = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
                clkout_nxt = clkout_r;
            end
            tick_nxt = rise_s;
            if (rise_s) begin
                bcnt_nxt = bcnt_inc_s;
            end else begin
                bcnt_nxt = bcnt_r;
            end
            if (burst_hit_s) begin
                burst_stop_nxt = 1'b1;
            end else begin
                burst_stop_nxt = burst_stop_r;
            end
        end
    end

    // Datapath, configuration and output registers.
    always_ff @(posedge clkin or negedge resetn) begin
        if (!resetn) begin
            half_r       <= CNT_W'(DEF_HALF);
            burst_r      <= BURST_W'(DEF_BURST);
            cnt_r        <= {CNT_W{1'b0}};
            bcnt_r       <= {BURST_W{1'b0}};
            clkout_r     <= 1'b0;
            tick_r       <= 1'b0;
            done_r       <= 1'b0;
            busy_r       <= 1'b0;
            cfg_ready_r  <= 1'b1;
            burst_stop_r <= 1'b0;
        end else begin
            half_r       <= half_nxt;
            burst_r      <= burst_nxt;
            cnt_r        <= cnt_nxt;
            bcnt_r       <= bcnt_nxt;
            clkout_r     <= clkout_nxt;
            tick_r       <= tick_nxt;
            done_r       <= done_nxt;
            busy_r       <= (state_nxt != ST_IDLE);
            cfg_ready_r  <= (state_nxt == ST_IDLE);
            burst_stop_r <= burst_stop_nxt;
        end
    end

    assign clkout    = clkout_r;
    assign tick      = tick_r;
    assign busy      = busy_r;
    assign done      = done_r;
    assign cfg_ready = cfg_ready_r;

endmodule

// File: doc/clk_div_ctrl.md
Name: clk_div_ctrl

Overview:
Programmable controller for the divided-clock generator. It holds the divider configuration (half-period count, burst length) behind a valid/ready load port and sequences start, stop and burst operation. It produces a glitch-free divided clock plus a one-cycle tick on each divided rising edge. It sits between the CPU/control FSM and any logic clocked or enabled by the slow clock, and replaces fixed-ratio division.

Parameters:
CNT_W, 32, width of half-period counter and cfg_half
BURST_W, 16, width of burst length and burst counter
DEF_HALF, 25, reset value of half-period register (toggle every 26 clkin cycles)
DEF_BURST, 0, reset value of burst register (0 = free-run)

Ports:
clkin  in  1  system clock; all logic on posedge
resetn  in  1  asynchronous, active-low reset
cfg_valid  in  1  config write request
cfg_ready  out  1  high only in IDLE
cfg_half  in  CNT_W  half-period value H; clkout toggles when cnt==H
cfg_burst  in  BURST_W  number of divided rising edges to emit; 0 = free-run
start  in  1  level-sampled start request
stop  in  1  level-sampled stop request
clkout  out  1  divided clock, registered
tick  out  1  one-cycle pulse, high in the same cycle clkout first reads 1
busy  out  1  high in RUN or STOPPING
done  out  1  one-cycle pulse on burst completion

Behaviour:
- Reset (resetn=0, async): state=IDLE, cnt=0, bcnt=0, clkout=0, tick=0, done=0, busy=0, half_r=DEF_HALF, burst_r=DEF_BURST.
- States: IDLE, RUN, STOPPING. busy = (state!=IDLE). cfg_ready = (state==IDLE).
- IDLE:
  - cfg_valid&&cfg_ready latches cfg_half and cfg_burst.
  - If start=1 and stop=0, go to RUN next cycle with cnt=0, bcnt=0, clkout=0.
  - If start and cfg_valid occur in the same cycle, the run uses the newly written values.
  - If start and stop occur in the same cycle, stop wins and the block stays IDLE.
- RUN:
  - cnt increments each cycle. When cnt==half_r, cnt<=0 and clkout toggles.
  - H=0 gives a toggle every cycle, so the divided period is 2(H+1) clkin cycles.
  - On a 0->1 toggle, tick is asserted for one cycle aligned with clkout=1, and bcnt increments (saturating at all-ones).
  - With burst_r!=0: after the 0->1 toggle that makes bcnt==burst_r, go to STOPPING.
  - With burst_r==0: run until stop.
  - start is ignored. cfg_valid is not accepted.
- STOPPING:
  - Counting continues. When the next 1->0 toggle occurs, go to IDLE with cnt cleared and clkout=0.
  - done pulses in the cycle clkout reads 0, but only if the stop was caused by burst completion.
- stop in RUN:
  - If clkout==0 when stop is sampled, go to IDLE next cycle with cnt=0 and no done.
  - If clkout==1, go to STOPPING, which finishes the high phase with no done.
  - Consequence: clkout never has a high phase shorter than H+1 cycles (glitch-free).
- stop in the same cycle as the final burst rising toggle: burst completion takes precedence, and done still pulses.
- Latency: start sampled at cycle t gives RUN at t+1, first tick/clkout=1 at t+2+H, and each subsequent rise 2(H+1) cycles later.
- Config registers are not affected by stop, done or burst end; they persist until rewritten or reset.
- resetn asserted mid-run: everything returns to reset values immediately (async), including the config registers.

Test Plan:
- Reset then start with defaults (H=25, burst=0) -> clkout period 52 cycles, first tick 27 cycles after the start-sample edge, busy=1 continuously, no done.
- Write H=2, burst=3 then start at cycle 0 -> ticks at cycles 4, 10, 16; clkout falls at 19; done=1 and busy=0 at cycle 19; exactly 3 ticks.
- H=0, burst=0, start, stop asserted while clkout=1 -> clkout completes its 1-cycle high then drops; IDLE follows; no done; no runt pulse.
- cfg_valid during RUN (H=5) -> cfg_ready=0 and the period stays 12 cycles; after returning to IDLE, the write is accepted and the next run uses the new H.
- start+stop in the same IDLE cycle -> stays IDLE, busy=0. start+cfg_valid (H=1) in the same cycle -> run period is 4 cycles.
- resetn low for 1 cycle mid-burst (H=3, burst=10) -> clkout, tick and busy are 0 immediately and half_r returns to 25; a following start runs with the defaults.
